spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- SPI slave endpoint that sits directly downstream of the SPI master.
- Consumes one chip-select line (SS_N, driven from one of the master's SSx outputs), SCK and MOSI, and drives MISO back.
- Oversamples all SPI pins in its own CLOCK domain, assembles an LSB-first receive word, and presents it with a valid/ack handshake.
- Shifts out a preloaded transmit word on MISO, which is what the master's read path captures.

Parameters:
DATA_W, 64, maximum frame length in bits; rx_data/tx_data width
SYNC_STAGES, 2, flip-flop depth of the SCK/SS_N/MOSI synchronizers (>=2)
CNT_W, 7, bit counter width; must hold DATA_W

Ports:
CLOCK  in  1  system clock; all logic on rising edge
RST  in  1  asynchronous, active-low reset
SCK  in  1  SPI clock from master, asynchronous to CLOCK
SS_N  in  1  slave select, active-low, asynchronous
MOSI  in  1  serial data from master
MISO  out  1  serial data to master
M  in  2  mode: 2 = sample on SCK rise, 1 = sample on SCK fall; 0/3 treated as 2
tx_data  in  DATA_W  word to return on MISO, LSB first
tx_load  in  1  load tx_data into transmit shadow register
tx_ready  out  1  high when tx_load will be accepted
rx_data  out  DATA_W  received word; bit n = n-th MOSI bit sampled
rx_len  out  CNT_W  number of bits received in the frame (0..DATA_W)
rx_valid  out  1  rx_data/rx_len valid; held until rx_ack
rx_ack  in  1  consumer accepts current rx word
overrun  out  1  one-cycle pulse: frame completed while rx_valid was still high

Behaviour:
- Reset (RST low, async) forces:
  - state = IDLE
  - MISO = 0, tx_ready = 1, rx_valid = 0, overrun = 0
  - rx_data = 0, rx_len = 0
  - bit counter = 0, shift/shadow registers = 0
  - synchronizers = SS_N high, SCK low
- Input sampling:
  - SCK, SS_N and MOSI pass through SYNC_STAGES flops plus one history flop; edges are detected on the synchronized values.
  - Sample edge is SCK rise (M=2, 0, 3) or SCK fall (M=1); shift edge is the opposite edge.
  - Supported SCK half-period is >= SYNC_STAGES+1 CLOCK cycles; faster SCK is out of scope.
- State machine:
  - IDLE -> ACTIVE on synchronized SS_N falling edge:
    - bit counter cleared, rx working register cleared
    - MISO = tx shadow[0]
  - ACTIVE, sample edge with counter < DATA_W: rx_work[counter] <= MOSI_sync, counter++.
  - ACTIVE, sample edge with counter == DATA_W: bit ignored, counter saturates.
  - ACTIVE, shift edge: tx shadow shifts right one bit (zero fill); MISO takes the new bit 0. The first shift edge before any sample edge is ignored, so bit 0 is held for a full SCK period.
  - ACTIVE -> DONE on synchronized SS_N rising edge.
  - DONE (one cycle):
    - If counter > 0: rx_data <= rx_work, rx_len <= counter, rx_valid <= 1.
    - If rx_valid was already 1 and not acked this cycle: overrun pulses for 1 cycle; old word is overwritten.
    - Counter 0 (empty frame): no update, no rx_valid.
    - Always proceeds to IDLE.
- rx_valid falls on the cycle after rx_ack is high. If rx_ack and a new DONE coincide, the new word is loaded, rx_valid stays 1, and overrun stays 0.
- Latency: rx_valid rises SYNC_STAGES+2 CLOCK cycles after the raw SS_N rise (synchronized edge detect, then DONE).
- tx_ready = 1 only in IDLE. tx_load while tx_ready copies tx_data to the shadow register. tx_load outside IDLE is ignored; the shadow is not modified.
- The shadow is consumed by shifting and is not auto-reloaded; a frame with no new tx_load transmits zeros after previously shifted-out bits.
- MISO = 0 whenever state != ACTIVE (no tristate).
- Async reset mid-frame aborts immediately. After reset, the block waits for a fresh SS_N fall; a partially asserted SS_N is not treated as a start.

Decomposition:
- Package spi_pkg:
  - state enum {IDLE, ACTIVE, DONE}
  - mode constants SPI_MODE_NEG = 2'd1, SPI_MODE_POS = 2'd2
  - default DATA_W
- Sub-module spi_pin_sync:
  - SYNC_STAGES synchronizer + history flop for one pin
  - outputs sync value, rise pulse, fall pulse
  - instantiated for SCK, SS_N and MOSI (edge outputs unused for MOSI)

Test Plan:
1. tx_load 0xA5, master M=2, 8-bit write of 0x3C, SCK half-period 4 CLOCKs -> rx_data = 0x3C, rx_len = 8, rx_valid = 1; MISO bits seen by master LSB first = 1,0,1,0,0,1,0,1.
2. Same frame with M=1 -> identical rx_data/rx_len; sampling occurs on falling SCK (check via a MOSI transition placed only before the fall).
3. 70-bit frame of all ones -> rx_data = all 64 bits set, rx_len = 64, no wrap into bit 0.
4. Two back-to-back 8-bit frames (0x11 then 0x22) without rx_ack -> overrun pulses once, rx_data = 0x22. Repeat with rx_ack coincident with the second DONE -> overrun = 0.
5. SS_N low then high with no SCK edges -> rx_valid stays 0, state returns to IDLE.
6. RST low after 5 bits of a frame -> MISO = 0, rx_valid = 0, tx_ready = 1 immediately. Next full 8-bit frame 0x81 -> rx_data = 0x81, rx_len = 8.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_e;

    localparam logic [1:0] SPI_MODE_NEG = 2'd1;
    localparam logic [1:0] SPI_MODE_POS = 2'd2;

    localparam int unsigned DATA_W_DEFAULT = 64;

    // Every mode other than NEG samples on the rising SCK edge.
    function automatic logic samples_on_rise(logic [1:0] mode);
        return mode != SPI_MODE_NEG;
    endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pins plus the transmit-load and receive valid/ack handshakes of the slave.
interface spi_slave_rx_if #(
    parameter int unsigned DATA_W = spi_pkg::DATA_W_DEFAULT,
    parameter int unsigned CNT_W  = 7
);
    logic              SCK;
    logic              SS_N;
    logic              MOSI;
    logic              MISO;
    logic [1:0]        M;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic [CNT_W-1:0]  rx_len;
    logic              rx_valid;
    logic              rx_ack;
    logic              overrun;

    modport slave (
        input  SCK, SS_N, MOSI, M, tx_data, tx_load, rx_ack,
        output MISO, tx_ready, rx_data, rx_len, rx_valid, overrun
    );

    modport master (
        output SCK, SS_N, MOSI, M, tx_data, tx_load, rx_ack,
        input  MISO, tx_ready, rx_data, rx_len, rx_valid, overrun
    );

endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer with a history flop and edge pulses for one async pin.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   hist_q;
    logic [SYNC_STAGES:0]   prime_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q  <= RESET_VAL;
            prime_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], pin};
            hist_q  <= chain_q[SYNC_STAGES-1];
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are suppressed until the chain and history hold real pin samples, so a
    // level already present at reset release never looks like a transition.
    always_comb begin
        sync = chain_q[SYNC_STAGES-1];
        rise = prime_q[SYNC_STAGES] & sync & ~hist_q;
        fall = prime_q[SYNC_STAGES] & ~sync & hist_q;
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave: oversampled pins, LSB-first receive word with valid/ack, shadowed MISO word.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 7
) (
    input logic           CLOCK,
    input logic           RST,
    spi_slave_rx_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    state_e state_q, state_d;

    logic              sck_rise, sck_fall, ss_rise, ss_fall, mosi_sync;
    logic              unused_sck_sync, unused_ss_sync, unused_mosi_rise, unused_mosi_fall;
    logic              sample_edge, shift_edge;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rx_work_q, shadow_q, rx_data_q;
    logic [CNT_W-1:0]  rx_len_q;
    logic              rx_valid_q, overrun_q, miso_q, seen_q;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk(CLOCK), .rst_n(RST), .pin(bus.SCK),
        .sync(unused_sck_sync), .rise(sck_rise), .fall(sck_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk(CLOCK), .rst_n(RST), .pin(bus.SS_N),
        .sync(unused_ss_sync), .rise(ss_rise), .fall(ss_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(CLOCK), .rst_n(RST), .pin(bus.MOSI),
        .sync(mosi_sync), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    assign sample_edge = samples_on_rise(bus.M) ? sck_rise : sck_fall;
    assign shift_edge  = samples_on_rise(bus.M) ? sck_fall : sck_rise;

    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall) state_d = ACTIVE;
            ACTIVE:  if (ss_rise) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.MISO     = 1'b0;
        bus.tx_ready = 1'b0;
        if (state_q == ACTIVE) bus.MISO = miso_q;
        if (state_q == IDLE)   bus.tx_ready = 1'b1;
    end

    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            cnt_q      <= '0;
            rx_work_q  <= '0;
            shadow_q   <= '0;
            rx_data_q  <= '0;
            rx_len_q   <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            miso_q     <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (bus.rx_ack) rx_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.tx_load) shadow_q <= bus.tx_data;
                    if (ss_fall) begin
                        cnt_q     <= '0;
                        rx_work_q <= '0;
                        miso_q    <= shadow_q[0];
                        seen_q    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (sample_edge) begin
                        seen_q <= 1'b1;
                        if (cnt_q < CNT_W'(DATA_W)) begin
                            rx_work_q[cnt_q[IDX_W-1:0]] <= mosi_sync;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    // A shift edge ahead of the first sample keeps bit 0 on MISO.
                    if (shift_edge && seen_q) begin
                        shadow_q <= shadow_q >> 1;
                        miso_q   <= shadow_q[1];
                    end
                end
                DONE: begin
                    if (cnt_q != '0) begin
                        rx_data_q  <= rx_work_q;
                        rx_len_q   <= cnt_q;
                        rx_valid_q <= 1'b1;
                        overrun_q  <= rx_valid_q & ~bus.rx_ack;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_len   = rx_len_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: a behavioural SPI master plus a word-level model of rx and MISO.
module tb_spi_slave_rx;
    import spi_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned SS = 2;
    localparam int unsigned CW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   ovr_cnt = 0;
    logic [63:0] shadow_m = '0;

    spi_slave_rx_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .CLOCK(clk),
        .RST(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic load_tx(input logic [63:0] v);
        bus.tx_data = v;
        bus.tx_load = 1'b1;
        tick(1);
        bus.tx_load = 1'b0;
        shadow_m = v;
    endtask

    task automatic ack_word();
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick(1);
            if (bus.rx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected receive word: the first min(n, 64) MOSI bits, LSB = first bit.
    function automatic logic [63:0] exp_rx(input int n, input logic [127:0] d);
        logic [127:0] m;
        int k;
        k = (n > 64) ? 64 : n;
        m = d & ((128'd1 << k) - 128'd1);
        return m[63:0];
    endfunction

    function automatic int exp_len(input int n);
        return (n > 64) ? 64 : n;
    endfunction

    // One SCK period; MOSI carries the wrong level on the non-sampling half.
    task automatic sck_bit(input logic b, input bit pos, input int h, output logic m);
        m = 1'b0;
        tick(2);
        bus.MOSI = pos ? b : ~b;
        tick(h - 2);
        if (pos) m = bus.MISO;
        bus.SCK = 1'b1;
        tick(2);
        bus.MOSI = pos ? ~b : b;
        tick(h - 2);
        if (!pos) m = bus.MISO;
        bus.SCK = 1'b0;
    endtask

    task automatic run_frame(input int n, input logic [127:0] d, input logic [1:0] mode,
                             input int h, input bit mid_load,
                             output logic [127:0] mb, output logic [127:0] em);
        bit   pos;
        logic m;
        int   shifts;
        pos = (mode != SPI_MODE_NEG);
        mb = '0;
        em = {64'd0, shadow_m} & ((128'd1 << n) - 128'd1);
        bus.M = mode;
        bus.SCK = 1'b0;
        tick(4);
        bus.SS_N = 1'b0;
        tick(8);
        for (int i = 0; i < n; i++) begin
            if (mid_load && i == n / 2) begin
                bus.tx_data = {$urandom, $urandom};
                bus.tx_load = 1'b1;
                n_vec++;
                if (bus.tx_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL tx_ready_in_frame: got %b want 0", bus.tx_ready);
                end
                tick(1);
                bus.tx_load = 1'b0;
            end
            sck_bit(d[i], pos, h, m);
            mb[i] = m;
        end
        tick(h);
        bus.SS_N = 1'b1;
        shifts = (n == 0) ? 0 : (pos ? n : n - 1);
        shadow_m = (shifts >= 64) ? 64'd0 : (shadow_m >> shifts);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        n_vec += 4;
        if (bus.MISO !== 1'b0 || bus.tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pins: MISO=%b tx_ready=%b want 0/1", bus.MISO, bus.tx_ready);
        end
        if (bus.rx_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: rx_valid=%b overrun=%b want 0/0",
                     bus.rx_valid, bus.overrun);
        end
        if (bus.rx_data !== 64'd0) begin
            n_err++;
            $display("FAIL reset_rx_data: got %h want 0", bus.rx_data);
        end
        if (bus.rx_len !== 7'd0) begin
            n_err++;
            $display("FAIL reset_rx_len: got %0d want 0", bus.rx_len);
        end
        rst_n = 1'b1;
        shadow_m = '0;
        tick(6);
    endtask

    task automatic test_pos_mode();
        logic [127:0] mb, em;
        load_tx(64'hA5);
        run_frame(8, 128'h3C, SPI_MODE_POS, 4, 1'b0, mb, em);
        tick(SS + 1);
        n_vec += 2;
        if (bus.rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pos_latency_early: rx_valid=%b want 0", bus.rx_valid);
        end
        tick(1);
        if (bus.rx_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pos_latency: rx_valid=%b want 1", bus.rx_valid);
        end
        n_vec += 3;
        if (bus.rx_data !== 64'h3C || bus.rx_len !== 7'd8) begin
            n_err++;
            $display("FAIL pos_rx: data=%h len=%0d want 3c/8", bus.rx_data, bus.rx_len);
        end
        if (mb[7:0] !== 8'hA5) begin
            n_err++;
            $display("FAIL pos_miso: got %h want a5", mb[7:0]);
        end
        ack_word();
        if (bus.rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pos_ack: rx_valid=%b want 0", bus.rx_valid);
        end
    endtask

    task automatic test_neg_mode();
        logic [127:0] mb, em;
        bit ok;
        load_tx(64'hA5);
        run_frame(8, 128'h3C, SPI_MODE_NEG, 4, 1'b0, mb, em);
        wait_valid(ok);
        n_vec += 2;
        if (!ok || bus.rx_data !== 64'h3C || bus.rx_len !== 7'd8) begin
            n_err++;
            $display("FAIL neg_rx: ok=%b data=%h len=%0d want 1/3c/8",
                     ok, bus.rx_data, bus.rx_len);
        end
        if (mb !== em) begin
            n_err++;
            $display("FAIL neg_miso: got %h want %h", mb, em);
        end
        ack_word();
    endtask

    task automatic test_long_frame();
        logic [127:0] mb, em, d;
        bit ok;
        for (int t = 0; t < 2; t++) begin
            load_tx({$urandom, $urandom});
            d = (t == 0) ? {58'd0, {70{1'b1}}} : {64'd0, $urandom, $urandom | 32'd1};
            run_frame(70, d, SPI_MODE_POS, 4, 1'b0, mb, em);
            wait_valid(ok);
            n_vec += 2;
            if (!ok || bus.rx_data !== d[63:0] || bus.rx_len !== 7'd64) begin
                n_err++;
                $display("FAIL long_rx%0d: data=%h len=%0d want %h/64",
                         t, bus.rx_data, bus.rx_len, d[63:0]);
            end
            if (mb !== em) begin
                n_err++;
                $display("FAIL long_miso%0d: got %h want %h", t, mb, em);
            end
            ack_word();
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] mb, em;
        bit ok;
        int base;
        base = ovr_cnt;
        run_frame(8, 128'h11, SPI_MODE_POS, 5, 1'b0, mb, em);
        wait_valid(ok);
        run_frame(8, 128'h22, SPI_MODE_POS, 5, 1'b0, mb, em);
        tick(SS + 4);
        n_vec += 2;
        if (ovr_cnt - base !== 1) begin
            n_err++;
            $display("FAIL overrun_count: got %0d want 1", ovr_cnt - base);
        end
        if (!ok || bus.rx_valid !== 1'b1 || bus.rx_data !== 64'h22) begin
            n_err++;
            $display("FAIL overrun_data: valid=%b data=%h want 1/22", bus.rx_valid, bus.rx_data);
        end
        base = ovr_cnt;
        run_frame(8, 128'h33, SPI_MODE_POS, 5, 1'b0, mb, em);
        tick(SS + 1);
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
        n_vec += 2;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 64'h33) begin
            n_err++;
            $display("FAIL ack_coincide_data: valid=%b data=%h want 1/33",
                     bus.rx_valid, bus.rx_data);
        end
        tick(3);
        if (ovr_cnt - base !== 0) begin
            n_err++;
            $display("FAIL ack_coincide_overrun: got %0d want 0", ovr_cnt - base);
        end
        ack_word();
    endtask

    task automatic test_empty_frame();
        tick(2);
        bus.SS_N = 1'b0;
        tick(10);
        bus.SS_N = 1'b1;
        tick(12);
        n_vec++;
        if (bus.rx_valid !== 1'b0 || bus.tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL empty_frame: rx_valid=%b tx_ready=%b want 0/1",
                     bus.rx_valid, bus.tx_ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] mb, em;
        logic m;
        bit ok;
        run_frame(4, 128'h9, SPI_MODE_POS, 4, 1'b0, mb, em);
        wait_valid(ok);
        load_tx(64'hFFFF_FFFF_FFFF_FFFF);
        bus.M = SPI_MODE_POS;
        tick(2);
        bus.SS_N = 1'b0;
        tick(8);
        for (int i = 0; i < 5; i++) sck_bit(1'b1, 1'b1, 4, m);
        n_vec++;
        if (!ok || bus.MISO !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_state: ok=%b MISO=%b want 1/1", ok, bus.MISO);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.MISO !== 1'b0 || bus.rx_valid !== 1'b0 || bus.tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: MISO=%b rx_valid=%b tx_ready=%b want 0/0/1",
                     bus.MISO, bus.rx_valid, bus.tx_ready);
        end
        shadow_m = '0;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        n_vec++;
        if (bus.tx_ready !== 1'b1 || bus.rx_len !== 7'd0) begin
            n_err++;
            $display("FAIL held_ss_no_start: tx_ready=%b rx_len=%0d want 1/0",
                     bus.tx_ready, bus.rx_len);
        end
        bus.SS_N = 1'b1;
        tick(6);
        run_frame(8, 128'h81, SPI_MODE_POS, 4, 1'b0, mb, em);
        wait_valid(ok);
        n_vec += 2;
        if (!ok || bus.rx_data !== 64'h81 || bus.rx_len !== 7'd8) begin
            n_err++;
            $display("FAIL post_reset_rx: ok=%b data=%h len=%0d want 1/81/8",
                     ok, bus.rx_data, bus.rx_len);
        end
        if (mb !== 128'd0) begin
            n_err++;
            $display("FAIL post_reset_miso: got %h want 0", mb);
        end
        ack_word();
    endtask

    task automatic test_tx_load_ignored();
        logic [127:0] mb, em, d;
        bit ok;
        load_tx({$urandom, $urandom});
        d = {64'd0, $urandom, $urandom};
        run_frame(16, d, SPI_MODE_POS, 5, 1'b1, mb, em);
        wait_valid(ok);
        n_vec++;
        if (!ok || mb !== em || bus.rx_data !== exp_rx(16, d)) begin
            n_err++;
            $display("FAIL tx_load_ignored: ok=%b miso=%h want %h data=%h want %h",
                     ok, mb, em, bus.rx_data, exp_rx(16, d));
        end
        ack_word();
    endtask

    task automatic test_random();
        logic [127:0] mb, em, d;
        logic [1:0] mode;
        int n, h;
        bit ok;
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(1, 70);
            h = $urandom_range(4, 7);
            mode = 2'($urandom_range(0, 3));
            d = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) load_tx({$urandom, $urandom});
            run_frame(n, d, mode, h, 1'b0, mb, em);
            wait_valid(ok);
            n_vec += 3;
            if (!ok || bus.rx_data !== exp_rx(n, d)) begin
                n_err++;
                $display("FAIL rand_data[%0d] n=%0d m=%0d: got %h want %h",
                         t, n, mode, bus.rx_data, exp_rx(n, d));
            end
            if (bus.rx_len !== 7'(exp_len(n))) begin
                n_err++;
                $display("FAIL rand_len[%0d]: got %0d want %0d", t, bus.rx_len, exp_len(n));
            end
            if (mb !== em) begin
                n_err++;
                $display("FAIL rand_miso[%0d] n=%0d m=%0d: got %h want %h", t, n, mode, mb, em);
            end
            ack_word();
        end
    endtask

    initial begin
        bus.SCK = 1'b0;
        bus.SS_N = 1'b1;
        bus.MOSI = 1'b0;
        bus.M = SPI_MODE_POS;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;
        bus.rx_ack = 1'b0;
        test_reset();
        test_pos_mode();
        test_neg_mode();
        test_long_frame();
        test_back_to_back();
        test_empty_frame();
        test_reset_mid_frame();
        test_tx_load_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
